// File: rtl/device_req_bridge_pkg.sv
// Shared types and constants for the AXI4-Lite to device-helper request bridge.
package device_req_bridge_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_BRESP,
        ST_RRESP
    } state_t;

endpackage

// File: rtl/device_req_bridge_dec.sv
// Address window compare for the bridge's decode-error option
// (only instantiated when DEVICE_REQ_BRIDGE_DECERR_EN is defined).
module device_req_bridge_dec
    import device_req_bridge_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ADDR_BASE = 32'h4060_0000,
    parameter logic [ADDR_W-1:0] ADDR_SIZE = 32'h0001_0000
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit
);

    // Offset below ADDR_BASE wraps to a large value, so one unsigned compare covers both bounds.
    always_comb begin
        hit = (addr - ADDR_BASE) < ADDR_SIZE;
    end

endmodule

// File: rtl/device_req_bridge.sv
// AXI4-Lite slave bridging single-beat reads/writes onto the one-cycle
// device helper request/response port, one transaction in flight.
// Optional: DEVICE_REQ_BRIDGE_DECERR_EN answers out-of-window accesses with
// DECERR without issuing a helper request.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | accepting AW/W/AR into holding regs, arbitrating a request
// ST_ISSUE   | dev_req_valid high for this single cycle
// ST_CAPTURE | helper read data valid, latched into rdata
// ST_BRESP   | bvalid high, waiting for bready
// ST_RRESP   | rvalid high, waiting for rready; rdata/rresp frozen
module device_req_bridge
    import device_req_bridge_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ADDR_BASE = 32'h4060_0000,
    parameter logic [ADDR_W-1:0] ADDR_SIZE = 32'h0001_0000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              wvalid,
    output logic              wready,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    output logic              bvalid,
    input  logic              bready,
    output logic [1:0]        bresp,
    input  logic              arvalid,
    output logic              arready,
    input  logic [ADDR_W-1:0] araddr,
    output logic              rvalid,
    input  logic              rready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              dev_req_valid,
    output logic              dev_req_wen,
    output logic [ADDR_W-1:0] dev_req_addr,
    output logic [DATA_W-1:0] dev_req_wdata,
    output logic [STRB_W-1:0] dev_req_wmask,
    input  logic [DATA_W-1:0] dev_resp_rdata
);

    state_t              state;
    logic                rdy_en;
    logic                aw_full;
    logic                w_full;
    logic                ar_full;
    logic                last_wr;
    logic [ADDR_W-1:0]   aw_addr_q;
    logic [ADDR_W-1:0]   ar_addr_q;
    logic [DATA_W-1:0]   w_data_q;
    logic [STRB_W-1:0]   w_strb_q;
    logic                wr_rdy;
    logic                rd_rdy;
    logic                pick_wr;
    logic [ADDR_W-1:0]   sel_addr;
    logic                sel_hit;

    // rdy_en keeps the readys low while in reset and releases them one edge later.
    assign awready = rdy_en & ~aw_full & (state == ST_IDLE);
    assign wready  = rdy_en & ~w_full  & (state == ST_IDLE);
    assign arready = rdy_en & ~ar_full & (state == ST_IDLE);

    // Arbitration: a complete write and a read both pending alternate against the last winner.
    always_comb begin
        wr_rdy   = aw_full & w_full;
        rd_rdy   = ar_full;
        pick_wr  = wr_rdy & (~rd_rdy | ~last_wr);
        sel_addr = pick_wr ? aw_addr_q : ar_addr_q;
    end

`ifdef DEVICE_REQ_BRIDGE_DECERR_EN
    device_req_bridge_dec #(
        .ADDR_BASE (ADDR_BASE),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_dec (
        .addr (sel_addr),
        .hit  (sel_hit)
    );
`else
    logic unused_cfg;
    assign unused_cfg = ^{ADDR_BASE, ADDR_SIZE};
    assign sel_hit    = 1'b1;
`endif

    // Holding registers, request sequencing and registered AXI/helper outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= ST_IDLE;
            rdy_en        <= 1'b0;
            aw_full       <= 1'b0;
            w_full        <= 1'b0;
            ar_full       <= 1'b0;
            last_wr       <= 1'b0;
            aw_addr_q     <= '0;
            ar_addr_q     <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            dev_req_valid <= 1'b0;
            dev_req_wen   <= 1'b0;
            dev_req_addr  <= '0;
            dev_req_wdata <= '0;
            dev_req_wmask <= '0;
            bvalid        <= 1'b0;
            bresp         <= RESP_OKAY;
            rvalid        <= 1'b0;
            rresp         <= RESP_OKAY;
            rdata         <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (awvalid && awready) begin
                aw_full   <= 1'b1;
                aw_addr_q <= awaddr;
            end
            if (wvalid && wready) begin
                w_full   <= 1'b1;
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end
            if (arvalid && arready) begin
                ar_full   <= 1'b1;
                ar_addr_q <= araddr;
            end

            case (state)
                ST_IDLE: begin
                    if (wr_rdy || rd_rdy) begin
                        last_wr <= pick_wr;
                        if (!sel_hit) begin
                            // Out-of-window access: answer directly, helper never sees it.
                            if (pick_wr) begin
                                aw_full <= 1'b0;
                                w_full  <= 1'b0;
                                bvalid  <= 1'b1;
                                bresp   <= RESP_DECERR;
                                state   <= ST_BRESP;
                            end else begin
                                ar_full <= 1'b0;
                                rvalid  <= 1'b1;
                                rresp   <= RESP_DECERR;
                                rdata   <= '0;
                                state   <= ST_RRESP;
                            end
                        end else begin
                            dev_req_valid <= 1'b1;
                            dev_req_wen   <= pick_wr;
                            dev_req_addr  <= sel_addr;
                            dev_req_wdata <= pick_wr ? w_data_q : '0;
                            dev_req_wmask <= pick_wr ? w_strb_q : '0;
                            state         <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    dev_req_valid <= 1'b0;
                    if (dev_req_wen) begin
                        aw_full <= 1'b0;
                        w_full  <= 1'b0;
                        bvalid  <= 1'b1;
                        bresp   <= RESP_OKAY;
                        state   <= ST_BRESP;
                    end else begin
                        state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    rdata   <= dev_resp_rdata;
                    ar_full <= 1'b0;
                    rvalid  <= 1'b1;
                    rresp   <= RESP_OKAY;
                    state   <= ST_RRESP;
                end
                ST_BRESP: begin
                    if (bready) begin
                        bvalid <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                ST_RRESP: begin
                    if (rready) begin
                        rvalid <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_device_req_bridge.sv
// Self-checking bench for device_req_bridge: directed protocol cases followed
// by randomized single transactions against a byte-addressed memory model.
module tb_device_req_bridge;

    logic        clk = 1'b0;
    logic        rstn;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        dev_req_valid, dev_req_wen;
    logic [31:0] dev_req_addr, dev_req_wdata;
    logic [3:0]  dev_req_wmask;
    logic [31:0] dev_resp_rdata;

    device_req_bridge dut (
        .clk            (clk),
        .rstn           (rstn),
        .awvalid        (awvalid),
        .awready        (awready),
        .awaddr         (awaddr),
        .wvalid         (wvalid),
        .wready         (wready),
        .wdata          (wdata),
        .wstrb          (wstrb),
        .bvalid         (bvalid),
        .bready         (bready),
        .bresp          (bresp),
        .arvalid        (arvalid),
        .arready        (arready),
        .araddr         (araddr),
        .rvalid         (rvalid),
        .rready         (rready),
        .rdata          (rdata),
        .rresp          (rresp),
        .dev_req_valid  (dev_req_valid),
        .dev_req_wen    (dev_req_wen),
        .dev_req_addr   (dev_req_addr),
        .dev_req_wdata  (dev_req_wdata),
        .dev_req_wmask  (dev_req_wmask),
        .dev_resp_rdata (dev_resp_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        int          at;
    } req_t;

    req_t        dev_log[$];
    int          dev_cnt = 0;
    logic [31:0] helper_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    bit          rd_pend = 1'b0;
    logic [31:0] rd_addr;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] helper_rd(input logic [31:0] a);
        return helper_mem.exists(a) ? helper_mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    // Helper device: logs each request; read data is valid only in the cycle after the request.
    always @(negedge clk) begin
        if (rd_pend) dev_resp_rdata = helper_rd(rd_addr);
        else         dev_resp_rdata = $urandom;
        rd_pend = 1'b0;
        if (dev_req_valid) begin
            dev_log.push_back('{dev_req_wen, dev_req_addr, dev_req_wdata, dev_req_wmask, cyc});
            dev_cnt++;
            if (dev_req_wen) begin
                helper_mem[dev_req_addr] = merge(helper_rd(dev_req_addr), dev_req_wdata, dev_req_wmask);
            end else begin
                rd_pend = 1'b1;
                rd_addr = dev_req_addr;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, output int acc);
        bit aw_p, w_p, aw_go, w_go;
        int aw_at, w_at;
        aw_p = 1'b1; w_p = 1'b1; aw_at = 0; w_at = 0;
        for (int k = 0; k < 40 && (aw_p || w_p); k++) begin
            if (aw_p && k >= aw_dly) begin awvalid = 1'b1; awaddr = a; end
            if (w_p && k >= w_dly) begin wvalid = 1'b1; wdata = d; wstrb = s; end
            aw_go = awvalid && awready;
            w_go  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_go) begin awvalid = 1'b0; aw_p = 1'b0; aw_at = cyc; end
            if (w_go)  begin wvalid = 1'b0;  w_p = 1'b0;  w_at = cyc;  end
        end
        check("wr_accept", 64'({aw_p, w_p}), 64'(0));
        acc = (aw_at > w_at) ? aw_at : w_at;
    endtask

    task automatic send_ar(input logic [31:0] a, output int acc);
        bit p, go;
        p = 1'b1; acc = 0;
        for (int k = 0; k < 40 && p; k++) begin
            arvalid = 1'b1; araddr = a;
            go = arready;
            @(posedge clk); #1;
            if (go) begin arvalid = 1'b0; p = 1'b0; acc = cyc; end
        end
        check("ar_accept", 64'(p), 64'(0));
    endtask

    task automatic wait_b(input int exp_cyc, input logic [1:0] exp_resp, input int dly,
                          output int hs);
        int k, c0;
        k = 0;
        while (!bvalid && k < 50) begin @(posedge clk); #1; k++; end
        check("b_valid", 64'(bvalid), 64'(1));
        check("b_cycle", 64'(cyc), 64'(exp_cyc));
        check("bresp", 64'(bresp), 64'(exp_resp));
        c0 = dev_cnt;
        repeat (dly) begin @(posedge clk); #1; end
        if (dly > 0) begin
            check("b_hold", 64'(bvalid), 64'(1));
            check("b_hold_noreq", 64'(dev_cnt), 64'(c0));
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        hs = cyc;
        check("b_drop", 64'(bvalid), 64'(0));
    endtask

    task automatic wait_r(input int exp_cyc, input logic [31:0] exp_d, input logic [1:0] exp_resp,
                          input int dly, output int hs);
        int k, c0;
        k = 0;
        while (!rvalid && k < 50) begin @(posedge clk); #1; k++; end
        check("r_valid", 64'(rvalid), 64'(1));
        check("r_cycle", 64'(cyc), 64'(exp_cyc));
        check("rdata", 64'(rdata), 64'(exp_d));
        check("rresp", 64'(rresp), 64'(exp_resp));
        c0 = dev_cnt;
        repeat (dly) begin @(posedge clk); #1; end
        if (dly > 0) begin
            check("r_hold", 64'(rvalid), 64'(1));
            check("r_hold_data", 64'(rdata), 64'(exp_d));
            check("r_hold_noreq", 64'(dev_cnt), 64'(c0));
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        hs = cyc;
        check("r_drop", 64'(rvalid), 64'(0));
    endtask

    task automatic check_req(input logic wen, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] m, input int at);
        req_t r;
        check("req_count", 64'(dev_log.size()), 64'(1));
        if (dev_log.size() != 0) begin
            r = dev_log.pop_front();
            check("req_wen", 64'(r.wen), 64'(wen));
            check("req_addr", 64'(r.addr), 64'(a));
            check("req_cycle", 64'(r.at), 64'(at));
            if (wen) begin
                check("req_wdata", 64'(r.wdata), 64'(d));
                check("req_wmask", 64'(r.wmask), 64'(m));
            end
        end
        dev_log.delete();
    endtask

    initial begin
        int          acc, hs, c0, lead;
        logic [31:0] a, ar_a, d;
        logic [3:0]  s;

        rstn = 1'b0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b0; rready = 1'b0;
        awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", 64'(awready), 64'(0));
        check("rst_wready", 64'(wready), 64'(0));
        check("rst_arready", 64'(arready), 64'(0));
        check("rst_bvalid", 64'(bvalid), 64'(0));
        check("rst_rvalid", 64'(rvalid), 64'(0));
        check("rst_req_valid", 64'(dev_req_valid), 64'(0));
        check("rst_req_wen", 64'(dev_req_wen), 64'(0));
        check("rst_req_fields", 64'({dev_req_addr, dev_req_wmask}), 64'(0));
        check("rst_req_wdata", 64'(dev_req_wdata), 64'(0));
        check("rst_rdata", 64'(rdata), 64'(0));
        check("rst_resp", 64'({bresp, rresp}), 64'(0));
        rstn = 1'b1;
        @(posedge clk); #1;
        check("post_rst_readys", 64'({awready, wready, arready}), 64'(3'b111));

        // Write with AW and W in the same cycle.
        a = 32'h4060_0004; d = 32'hDEAD_BEEF;
        send_wr(a, d, 4'hF, 0, 0, acc);
        ref_mem[a] = merge(ref_rd(a), d, 4'hF);
        wait_b(acc + 2, 2'b00, 0, hs);
        check_req(1'b1, a, d, 4'hF, acc + 1);

        // W two cycles ahead of AW: W waits in its register, one request only.
        a = 32'h4060_0008; d = 32'h1234_5678;
        check("wfirst_wready_pre", 64'(wready), 64'(1));
        wvalid = 1'b1; wdata = d; wstrb = 4'hF;
        @(posedge clk); #1;
        wvalid = 1'b0;
        c0 = dev_cnt;
        check("wfirst_wready_drop", 64'(wready), 64'(0));
        check("wfirst_awready", 64'(awready), 64'(1));
        @(posedge clk); #1;
        check("wfirst_wready_held", 64'(wready), 64'(0));
        @(posedge clk); #1;
        check("wfirst_no_req", 64'(dev_cnt), 64'(c0));
        awvalid = 1'b1; awaddr = a;
        @(posedge clk); #1;
        awvalid = 1'b0; acc = cyc;
        ref_mem[a] = merge(ref_rd(a), d, 4'hF);
        wait_b(acc + 2, 2'b00, 0, hs);
        check_req(1'b1, a, d, 4'hF, acc + 1);
        check("wfirst_single_req", 64'(dev_cnt), 64'(c0 + 1));

        // Read back with rready held low for 5 cycles.
        send_ar(a, acc);
        wait_r(acc + 3, 32'h1234_5678, 2'b00, 5, hs);
        check_req(1'b0, a, 32'h0, 4'h0, acc + 1);

        // Zero strobe still reaches the helper, and leaves the data untouched.
        send_wr(a, 32'hFFFF_FFFF, 4'h0, 0, 0, acc);
        wait_b(acc + 2, 2'b00, 1, hs);
        check_req(1'b1, a, 32'hFFFF_FFFF, 4'h0, acc + 1);
        send_ar(a, acc);
        wait_r(acc + 3, 32'h1234_5678, 2'b00, 0, hs);
        check_req(1'b0, a, 32'h0, 4'h0, acc + 1);

        // Write and read pending together, twice: write, read, write, read.
        for (int round = 0; round < 2; round++) begin
            a    = 32'h4060_0010 + 32'(round) * 32'd4;
            ar_a = 32'h4060_0010;
            d    = $urandom;
            awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = 4'hF;
            arvalid = 1'b1; araddr = ar_a;
            @(posedge clk); #1;
            awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
            acc = cyc;
            ref_mem[a] = merge(ref_rd(a), d, 4'hF);
            wait_b(acc + 2, 2'b00, 0, hs);
            check_req(1'b1, a, d, 4'hF, acc + 1);
            acc = hs;
            wait_r(acc + 3, ref_rd(ar_a), 2'b00, 0, hs);
            check_req(1'b0, ar_a, 32'h0, 4'h0, acc + 1);
        end

`ifdef DEVICE_REQ_BRIDGE_DECERR_EN
        // Out-of-window accesses answered with DECERR, helper untouched.
        c0 = dev_cnt;
        send_ar(32'h1000_0000, acc);
        wait_r(acc + 1, 32'h0, 2'b11, 0, hs);
        send_wr(32'h1000_0000, 32'hCAFE_F00D, 4'hF, 0, 0, acc);
        wait_b(acc + 1, 2'b11, 0, hs);
        check("decerr_no_req", 64'(dev_cnt), 64'(c0));
`endif

        // Reset asserted during CAPTURE: no response, then a clean read.
        a = 32'h4060_0004;
        send_ar(a, acc);
        @(posedge clk); #1;
        check("rstmid_issue", 64'(dev_req_valid), 64'(1));
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        check("rstmid_rvalid", 64'(rvalid), 64'(0));
        check("rstmid_req", 64'(dev_req_valid), 64'(0));
        check("rstmid_arready", 64'(arready), 64'(0));
        check_req(1'b0, a, 32'h0, 4'h0, acc + 1);
        repeat (2) begin @(posedge clk); #1; check("rstmid_hold", 64'(rvalid), 64'(0)); end
        rstn = 1'b1;
        repeat (3) begin @(posedge clk); #1; check("rstmid_after", 64'(rvalid), 64'(0)); end
        check("rstmid_no_stray_req", 64'(dev_log.size()), 64'(0));
        send_ar(a, acc);
        wait_r(acc + 3, 32'hDEAD_BEEF, 2'b00, 1, hs);
        check_req(1'b0, a, 32'h0, 4'h0, acc + 1);

        // Randomized single transactions against the memory model.
        for (int it = 0; it < 40; it++) begin
            a = 32'h4060_0000 + 32'($urandom_range(0, 7)) * 32'd4;
            if ($urandom_range(0, 1) == 1) begin
                d    = $urandom;
                s    = 4'($urandom_range(0, 15));
                lead = int'($urandom_range(0, 4)) - 2;
                send_wr(a, d, s, (lead > 0) ? lead : 0, (lead < 0) ? -lead : 0, acc);
                ref_mem[a] = merge(ref_rd(a), d, s);
                wait_b(acc + 2, 2'b00, int'($urandom_range(0, 3)), hs);
                check_req(1'b1, a, d, s, acc + 1);
            end else begin
                send_ar(a, acc);
                wait_r(acc + 3, ref_rd(a), 2'b00, int'($urandom_range(0, 3)), hs);
                check_req(1'b0, a, 32'h0, 4'h0, acc + 1);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
